// File: rtl/data_memory_ctrl_if.sv
// Load/store bus for data_memory_ctrl. Define DMEM_DEBUG_PORT_EN to add the debug word-read port.
interface data_memory_ctrl_if #(
  parameter int unsigned NB_DATA_BUS = 32,
  parameter int unsigned NB_ADDRESS  = 10
);
  logic [NB_ADDRESS-1:0]  i_r_addr;
  logic                   i_r_en;
  logic [1:0]             i_r_addressing;
  logic                   i_r_unsigned;
  logic [NB_ADDRESS-1:0]  i_w_addr;
  logic [NB_DATA_BUS-1:0] i_w_data;
  logic                   i_w_en;
  logic [1:0]             i_w_addressing;
  logic [NB_DATA_BUS-1:0] o_r_data;
  logic                   o_r_valid;
  logic                   o_r_err;
  logic                   o_w_err;
  logic                   o_busy;
`ifdef DMEM_DEBUG_PORT_EN
  logic [NB_ADDRESS-3:0]  i_dbg_addr;
  logic [NB_DATA_BUS-1:0] o_dbg_data;

  modport master (
    output i_r_addr, i_r_en, i_r_addressing, i_r_unsigned,
    output i_w_addr, i_w_data, i_w_en, i_w_addressing, i_dbg_addr,
    input  o_r_data, o_r_valid, o_r_err, o_w_err, o_busy, o_dbg_data
  );
  modport slave (
    input  i_r_addr, i_r_en, i_r_addressing, i_r_unsigned,
    input  i_w_addr, i_w_data, i_w_en, i_w_addressing, i_dbg_addr,
    output o_r_data, o_r_valid, o_r_err, o_w_err, o_busy, o_dbg_data
  );
`else
  modport master (
    output i_r_addr, i_r_en, i_r_addressing, i_r_unsigned,
    output i_w_addr, i_w_data, i_w_en, i_w_addressing,
    input  o_r_data, o_r_valid, o_r_err, o_w_err, o_busy
  );
  modport slave (
    input  i_r_addr, i_r_en, i_r_addressing, i_r_unsigned,
    input  i_w_addr, i_w_data, i_w_en, i_w_addressing,
    output o_r_data, o_r_valid, o_r_err, o_w_err, o_busy
  );
`endif
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressable MEM-stage data memory with alignment checks, load extension and post-reset clear.
// Optional debug word-read port enabled by defining DMEM_DEBUG_PORT_EN.
module data_memory_ctrl #(
  parameter int unsigned NB_DATA_BUS = 32,
  parameter int unsigned NB_DATA     = 8,
  parameter int unsigned NB_ADDRESS  = 10
) (
  input logic               i_clk,
  input logic               i_rst,
  data_memory_ctrl_if.slave bus
);
  localparam int unsigned NB_WADDR  = NB_ADDRESS - 2;
  localparam int unsigned NUM_WORDS = 2 ** NB_WADDR;
  localparam int unsigned NUM_BYTES = NB_DATA_BUS / NB_DATA;
  localparam int unsigned NB_HALF   = 2 * NB_DATA;
  localparam logic [1:0]  ModeWord  = 2'b00;
  localparam logic [1:0]  ModeHalf  = 2'b01;
  localparam logic [1:0]  ModeByte  = 2'b11;

  typedef enum logic {StClear, StIdle} state_e;

  state_e                 state_q;
  logic [NB_WADDR-1:0]    clr_cnt_q;
  logic                   busy_q;
  logic                   r_valid_q;
  logic                   r_err_q;
  logic                   w_err_q;
  logic [NB_DATA_BUS-1:0] r_data_q;
  logic [NB_DATA_BUS-1:0] mem [NUM_WORDS];

  function automatic logic bad_access(input logic [1:0] lsb, input logic [1:0] mode);
    case (mode)
      ModeWord: return lsb != 2'b00;
      ModeHalf: return lsb[0];
      ModeByte: return 1'b0;
      default:  return 1'b1;
    endcase
  endfunction

  logic                   r_bad;
  logic                   w_bad;
  logic                   w_ok;
  logic [NB_DATA_BUS-1:0] r_word;
  logic [NB_DATA_BUS-1:0] r_shift;
  logic [NB_DATA_BUS-1:0] r_ext;
  logic [NB_DATA_BUS-1:0] w_word;
  logic [NUM_BYTES-1:0]   w_be;

  always_comb begin
    r_bad   = bad_access(bus.i_r_addr[1:0], bus.i_r_addressing);
    w_bad   = bad_access(bus.i_w_addr[1:0], bus.i_w_addressing);
    w_ok    = (state_q == StIdle) && !i_rst && bus.i_w_en && !w_bad;
    r_word  = mem[bus.i_r_addr[NB_ADDRESS-1:2]];
    r_shift = r_word >> (NB_DATA * bus.i_r_addr[1:0]);
    r_ext   = '0;
    case (bus.i_r_addressing)
      ModeWord: r_ext = r_word;
      ModeHalf: r_ext = {{(NB_DATA_BUS-NB_HALF){~bus.i_r_unsigned & r_shift[NB_HALF-1]}},
                         r_shift[NB_HALF-1:0]};
      ModeByte: r_ext = {{(NB_DATA_BUS-NB_DATA){~bus.i_r_unsigned & r_shift[NB_DATA-1]}},
                         r_shift[NB_DATA-1:0]};
      default:  r_ext = '0;
    endcase
    // Place the low bits of the write data into the addressed lanes.
    w_word = bus.i_w_data << (NB_DATA * bus.i_w_addr[1:0]);
    w_be   = '0;
    case (bus.i_w_addressing)
      ModeWord: w_be = '1;
      ModeHalf: w_be = NUM_BYTES'(3) << bus.i_w_addr[1:0];
      ModeByte: w_be = NUM_BYTES'(1) << bus.i_w_addr[1:0];
      default:  w_be = '0;
    endcase
  end

  // Array has no reset of its own; the clear sequencer zeroes it word by word.
  always_ff @(posedge i_clk) begin
    if (state_q == StClear) begin
      mem[clr_cnt_q] <= '0;
    end else if (w_ok) begin
      for (int unsigned b = 0; b < NUM_BYTES; b++) begin
        if (w_be[b]) mem[bus.i_w_addr[NB_ADDRESS-1:2]][b*NB_DATA +: NB_DATA] <=
            w_word[b*NB_DATA +: NB_DATA];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
      r_valid_q <= 1'b0;
      r_err_q   <= 1'b0;
      w_err_q   <= 1'b0;
      r_data_q  <= '0;
    end else begin
      r_valid_q <= 1'b0;
      w_err_q   <= 1'b0;
      unique case (state_q)
        StClear: begin
          clr_cnt_q <= clr_cnt_q + NB_WADDR'(1);
          if (clr_cnt_q == '1) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StIdle: begin
          if (bus.i_r_en) begin
            r_valid_q <= 1'b1;
            r_err_q   <= r_bad;
            r_data_q  <= r_bad ? '0 : r_ext;
          end
          w_err_q <= bus.i_w_en && w_bad;
        end
        default: state_q <= StClear;
      endcase
    end
  end

  assign bus.o_r_data  = r_data_q;
  assign bus.o_r_valid = r_valid_q;
  assign bus.o_r_err   = r_err_q;
  assign bus.o_w_err   = w_err_q;
  assign bus.o_busy    = busy_q;

`ifdef DMEM_DEBUG_PORT_EN
  logic [NB_DATA_BUS-1:0] dbg_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) dbg_q <= '0;
    else       dbg_q <= mem[bus.i_dbg_addr];
  end

  assign bus.o_dbg_data = dbg_q;
`endif
endmodule
